// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader
//   Periodically reads an 8-bit serial temperature sensor over a 3-wire link
//   (cs_n / sclk / sdo, MSB first, sampled on sclk rise). Each reading is
//   range-checked: 8'hFF means an open line and is flagged as an error.
//   Otherwise the reading is saturated to 0..31 and published on
//   `temperature` together with a one-cycle `temp_valid` strobe.
//
//   Optional macro TEMP_AVG_EN: publish a 4-entry moving average of the
//   saturated samples instead of the raw sample. The first good sample after
//   reset fills all four entries. Latency is the same with or without it.
//
// Parameters
//   SCLK_DIV        clk cycles per sensor_sclk half-period (>= 2)
//   SAMPLE_INTERVAL clk cycles from one conversion start to the next
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          run periodic conversions; low aborts any frame at once
//   sensor_sdo      serial data from the sensor
//   sensor_cs_n     sensor chip select (active low)
//   sensor_sclk     sensor serial clock (idles low)
//   temperature     processed temperature, unsigned degC, 0..31
//   temp_valid      one-cycle strobe: temperature updated
//   sensor_err      sticky: last completed frame was an open-line read
module temp_sensor_reader #(
  parameter int SCLK_DIV        = 4,
  parameter int SAMPLE_INTERVAL = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sensor_sdo,
  output logic       sensor_cs_n,
  output logic       sensor_sclk,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       sensor_err
);

  localparam int DW = $clog2(SCLK_DIV);
  // Interval counter saturates at SAMPLE_INTERVAL-1, so it never needs more.
  localparam int IW = (SAMPLE_INTERVAL > 2) ? $clog2(SAMPLE_INTERVAL) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt;
  logic [IW-1:0]   iv_cnt;
  logic [2:0]      fall_cnt;
  logic [7:0]      raw;
  logic            enable_q;

  logic            div_last, expire, en_rise, start;
  logic [4:0]      sat, temp_next;

  assign div_last = (div_cnt == DW'(SCLK_DIV - 1));
  assign expire   = (iv_cnt == IW'(SAMPLE_INTERVAL - 1));
  assign en_rise  = enable & ~enable_q;
  assign start    = (state_q == IDLE) && (state_d == SELECT);
  assign sat      = (raw > 8'd31) ? 5'd31 : raw[4:0];

`ifdef TEMP_AVG_EN
  // hist[3] is the oldest entry; sum_q always equals the sum of hist.
  logic [3:0][4:0] hist;
  logic [6:0]      sum_q, sum_d;
  logic            primed;

  always_comb begin
    sum_d = {sat, 2'b00};
    if (primed) sum_d = sum_q - {2'b00, hist[3]} + {2'b00, sat};
  end
  assign temp_next = sum_d[6:2];
`else
  assign temp_next = sat;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (expire || en_rise) state_d = SELECT;
        SELECT:  if (div_last) state_d = SHIFT;
        // sclk high + div_last means a falling edge; fall_cnt==7 -> the 8th
        SHIFT:   if (div_last && sensor_sclk && fall_cnt == 3'd7) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt     <= '0;
      iv_cnt      <= '0;
      fall_cnt    <= '0;
      raw         <= '0;
      enable_q    <= 1'b0;
      sensor_cs_n <= 1'b1;
      sensor_sclk <= 1'b0;
      temperature <= 5'd20;
      temp_valid  <= 1'b0;
      sensor_err  <= 1'b0;
`ifdef TEMP_AVG_EN
      hist        <= '0;
      sum_q       <= '0;
      primed      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      enable_q   <= enable;
      temp_valid <= 1'b0;
      if (!enable) begin
        // Abort: drop the link immediately, leave results untouched.
        sensor_cs_n <= 1'b1;
        sensor_sclk <= 1'b0;
        iv_cnt      <= '0;
      end else begin
        if (start)        iv_cnt <= '0;
        else if (!expire) iv_cnt <= iv_cnt + 1'b1;

        if (state_q == SELECT || state_q == SHIFT)
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;

        unique case (state_q)
          IDLE: begin
            div_cnt  <= '0;
            fall_cnt <= '0;
            if (start) sensor_cs_n <= 1'b0;
          end
          SELECT: begin
            // First rise; the sensor has presented the MSB since cs_n fell.
            if (div_last) begin
              sensor_sclk <= 1'b1;
              raw         <= {raw[6:0], sensor_sdo};
            end
          end
          SHIFT: begin
            if (div_last) begin
              sensor_sclk <= ~sensor_sclk;
              if (!sensor_sclk) begin
                raw <= {raw[6:0], sensor_sdo};
              end else begin
                fall_cnt <= fall_cnt + 1'b1;
                if (fall_cnt == 3'd7) sensor_cs_n <= 1'b1;
              end
            end
          end
          DONE: begin
            if (raw == 8'hFF) begin
              sensor_err <= 1'b1;
            end else begin
              sensor_err  <= 1'b0;
              temperature <= temp_next;
              temp_valid  <= 1'b1;
`ifdef TEMP_AVG_EN
              hist   <= primed ? {hist[2:0], sat} : {4{sat}};
              sum_q  <= sum_d;
              primed <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_temp_sensor_reader.sv
module tb_temp_sensor_reader;
  localparam int SCLK_DIV        = 4;
  localparam int SAMPLE_INTERVAL = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       sensor_sdo = 1'b0;
  logic       sensor_cs_n, sensor_sclk;
  logic [4:0] temperature;
  logic       temp_valid, sensor_err;

  temp_sensor_reader #(.SCLK_DIV(SCLK_DIV), .SAMPLE_INTERVAL(SAMPLE_INTERVAL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_sdo(sensor_sdo),
    .sensor_cs_n(sensor_cs_n), .sensor_sclk(sensor_sclk),
    .temperature(temperature), .temp_valid(temp_valid), .sensor_err(sensor_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Sensor: presents MSB when selected, next bit after each sclk fall.
  logic [7:0] sensor_byte = 8'h00;
  int         bidx = 7;
  bit         in_frame = 0;
  always @(negedge sensor_sclk or negedge sensor_cs_n or posedge sensor_cs_n) begin
    if (sensor_cs_n === 1'b1) begin
      in_frame = 0;
      bidx = 7;
    end else if (!in_frame) begin
      in_frame = 1;
    end else if (bidx > 0) begin
      bidx--;
    end
    sensor_sdo = sensor_byte[bidx];
  end

  // Reference model: what the reader should publish after each frame.
  logic [4:0] m_temp = 5'd20;
  logic       m_err = 1'b0;
  logic       m_valid = 1'b0;
  int         hist[$];

  function automatic void model_reset();
    m_temp = 5'd20;
    m_err  = 1'b0;
    hist.delete();
  endfunction

  function automatic void model_frame(input logic [7:0] v);
    int s;
    if (v == 8'hFF) begin
      m_err   = 1'b1;
      m_valid = 1'b0;
      return;
    end
    m_err   = 1'b0;
    m_valid = 1'b1;
    s = (v > 8'd31) ? 31 : int'(v);
`ifdef TEMP_AVG_EN
    begin
      int acc;
      if (hist.size() == 0) repeat (3) hist.push_back(s);
      hist.push_back(s);
      if (hist.size() > 4) void'(hist.pop_front());
      acc = 0;
      foreach (hist[i]) acc += hist[i];
      m_temp = 5'(acc / 4);
    end
`else
    m_temp = 5'(s);
`endif
  endfunction

  task automatic wait_cs_fall(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (sensor_cs_n === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: cs_n never fell within 250 cycles", nm);
    end
  endtask

  // Called at the negedge of cycle 0 (first cycle with cs_n low).
  task automatic check_frame(input logic [7:0] v, input string nm);
    int         low = 1, rises = 0, vcnt = 0, vcyc = -1;
    logic       prev = sensor_sclk;
    logic [4:0] vtemp = 5'd0, pre_temp = 5'd0;
    logic [4:0] old_temp = m_temp;
    model_frame(v);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (sensor_cs_n === 1'b0) low++;
      if (sensor_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sensor_sclk;
      if (temp_valid === 1'b1) begin
        vcnt++;
        vcyc  = k;
        vtemp = temperature;
      end
      if (k == 64) pre_temp = temperature;
    end
    n_checks++;
    if (low !== 16 * SCLK_DIV) $display("FAIL %s cs_low_cycles: got %0d want %0d", nm, low, 16 * SCLK_DIV);
    else n_pass++;
    n_checks++;
    if (rises !== 8) $display("FAIL %s sclk_rises: got %0d want 8", nm, rises);
    else n_pass++;
    n_checks++;
    if (pre_temp !== old_temp) $display("FAIL %s temp_before_strobe: got %0d want %0d", nm, pre_temp, old_temp);
    else n_pass++;
    n_checks++;
    if (vcnt !== (m_valid ? 1 : 0)) $display("FAIL %s strobe_count: got %0d want %0d", nm, vcnt, m_valid ? 1 : 0);
    else n_pass++;
    if (m_valid) begin
      n_checks++;
      if (vcyc !== 16 * SCLK_DIV + 1) $display("FAIL %s strobe_cycle: got %0d want %0d", nm, vcyc, 16 * SCLK_DIV + 1);
      else n_pass++;
      n_checks++;
      if (vtemp !== m_temp) $display("FAIL %s strobe_temp: got %0d want %0d", nm, vtemp, m_temp);
      else n_pass++;
    end
    n_checks++;
    if (temperature !== m_temp) $display("FAIL %s temp_after: got %0d want %0d", nm, temperature, m_temp);
    else n_pass++;
    n_checks++;
    if (sensor_err !== m_err) $display("FAIL %s sensor_err: got %0b want %0b", nm, sensor_err, m_err);
    else n_pass++;
  endtask

  task automatic run_frame(input logic [7:0] v, input string nm);
    bit ok;
    sensor_byte = v;
    wait_cs_fall(nm, ok);
    if (ok) check_frame(v, nm);
  endtask

  task automatic check_reset_vals(input string nm);
    logic [8:0] got, want;
    got  = {sensor_cs_n, sensor_sclk, temperature, temp_valid, sensor_err};
    want = {1'b1, 1'b0, 5'd20, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) $display("FAIL %s {cs_n,sclk,temp,valid,err}: got %b want %b", nm, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_initial");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw_read();
    bit ok;
    sensor_byte = 8'd19;
    enable = 1'b1;
    wait_cs_fall("raw19", ok);
    if (ok) check_frame(8'd19, "raw19");
  endtask

  task automatic test_saturation();
    run_frame(8'd45, "sat45");
    run_frame(8'd32, "sat32");
    run_frame(8'd31, "edge31");
  endtask

  task automatic test_error();
    run_frame(8'hFF, "err_ff");
    run_frame(8'd22, "after_err22");
    run_frame(8'hFE, "sat_fe");
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'hFF;
        1:       v = 8'($urandom_range(32, 254));
        2:       v = 8'($urandom_range(0, 31));
        default: v = 8'($urandom_range(0, 255));
      endcase
      run_frame(v, $sformatf("rand%0d_%0d", i, v));
    end
    run_frame(8'hFF, "err_before_reset");
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    sensor_byte = 8'd7;
    wait_cs_fall("reset_mid", ok);
    if (ok) begin
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid_async");
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("reset_mid_held");
      sensor_byte = 8'd16;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_average();
    logic [7:0] rd [4];
    logic [4:0] want_avg [4];
    rd = '{8'd16, 8'd18, 8'd20, 8'd23};
    want_avg = '{5'd16, 5'd16, 5'd17, 5'd19};
    for (int i = 0; i < 4; i++) begin
      run_frame(rd[i], $sformatf("avg_seq%0d", i));
`ifdef TEMP_AVG_EN
      n_checks++;
      if (temperature !== want_avg[i]) $display("FAIL avg_const%0d: got %0d want %0d", i, temperature, want_avg[i]);
      else n_pass++;
`else
      if (want_avg[i] == 5'd31) $display("note: unexpected table entry");
`endif
    end
  endtask

  task automatic test_abort();
    bit ok;
    int pulses = 0;
    sensor_byte = 8'd9;
    wait_cs_fall("abort", ok);
    if (ok) begin
      repeat (30) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sensor_cs_n !== 1'b1 || sensor_sclk !== 1'b0)
        $display("FAIL abort_link: got cs_n=%b sclk=%b want 1 0", sensor_cs_n, sensor_sclk);
      else n_pass++;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (temp_valid === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL abort_strobe: got %0d pulses want 0", pulses);
      else n_pass++;
      n_checks++;
      if (temperature !== m_temp || sensor_err !== m_err)
        $display("FAIL abort_hold: got temp=%0d err=%b want %0d %b", temperature, sensor_err, m_temp, m_err);
      else n_pass++;
      sensor_byte = 8'd27;
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sensor_cs_n !== 1'b0) $display("FAIL restart_cs: got cs_n=%b want 0", sensor_cs_n);
      else begin
        n_pass++;
        check_frame(8'd27, "restart27");
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_read();
    test_saturation();
    test_error();
    test_random();
    test_reset_mid_shift();
    test_average();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Upstream stage of the air-conditioning controller. It periodically reads an 8-bit serial temperature sensor over a 3-wire SPI-style link, range-checks and saturates each reading, optionally averages it, and presents a 5-bit `temperature` word with a one-cycle `temp_valid` strobe. The controller consumes that word to drive `heating` and `cooling`.

## Interface
- `SCLK_DIV`, default 4: `clk` cycles per `sensor_sclk` half-period, minimum 2.
- `SAMPLE_INTERVAL`, default 1000: `clk` cycles from one conversion start to the next.
- `clk` in 1: the single system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, periodic conversions run.
- `sensor_sdo` in 1: serial data from the sensor, MSB first.
- `sensor_cs_n` out 1: sensor chip select, active low.
- `sensor_sclk` out 1: sensor serial clock, idles low.
- `temperature` out 5: processed temperature, unsigned °C, range 0–31.
- `temp_valid` out 1: one-cycle pulse marking an updated `temperature`.
- `sensor_err` out 1: sticky flag indicating the last frame was invalid.

## Operation
- States and transitions:
  - IDLE → SELECT when `enable` is high and the interval counter expires, or on the cycle after `enable` rises.
  - SELECT → SHIFT after `SCLK_DIV` cycles.
  - SHIFT → DONE after the 8th falling edge.
  - DONE → IDLE after 1 cycle.
- SELECT drives `sensor_cs_n` low with `sensor_sclk` low, as setup time.
- SHIFT:
  - `sensor_sclk` toggles every `SCLK_DIV` cycles.
  - `sensor_sdo` is sampled into the raw shift register on each `sensor_sclk` rising edge, MSB first.
  - Exactly 8 rising edges occur per frame.
- DONE:
  - `sensor_cs_n` rises and `raw[7:0]` is evaluated.
  - If `raw == 8'hFF` (open line): `sensor_err` is set to 1, `temperature` holds, no `temp_valid`, and the sample is not entered into the averager.
  - Otherwise: `sensor_err` is cleared, the sample is `sat = (raw > 31) ? 5'd31 : raw[4:0]`, and `temperature` and `temp_valid` update per the Configuration section.
- `enable` low at any point:
  - Next cycle: `sensor_cs_n` is 1, `sensor_sclk` is 0, and the state is IDLE.
  - An aborted frame produces no `temp_valid` and no `sensor_err` change.
  - The interval counter resets.
- `SAMPLE_INTERVAL < 16*SCLK_DIV+2`: conversions run back-to-back with one IDLE cycle between them.

## Timing
- Reset values:
  - `sensor_cs_n` = 1, `sensor_sclk` = 0.
  - `temperature` = 5'd20, a neutral value so the controller neither heats nor cools.
  - `temp_valid` = 0, `sensor_err` = 0, state IDLE, interval counter 0.
  - Averager is unprimed.
- Relative to cycle 0 = the cycle `sensor_cs_n` falls:
  - First `sensor_sclk` rise at cycle `SCLK_DIV`.
  - 8th rise at cycle `15*SCLK_DIV`.
  - `sensor_sclk` falls and `sensor_cs_n` rises at cycle `16*SCLK_DIV`.
  - `temperature` and `temp_valid` update at cycle `16*SCLK_DIV+1`.
  - With the default `SCLK_DIV` this is cycle 65.
- `temp_valid` is exactly 1 cycle wide; `temperature` is stable between strobes.
- Asserting `rst_n` mid-frame forces all reset values immediately, without waiting for `clk`.

## Configuration
- Macro `TEMP_AVG_EN` defined:
  - 4-entry moving average of `sat` values.
  - `temperature = sum[6:0] >> 2`, truncating.
  - The first good sample after reset fills all 4 entries (priming).
  - Error frames are not entered.
  - Latency is unchanged.
- Macro `TEMP_AVG_EN` undefined: `temperature = sat` directly, and no averaging storage is built.

## Test plan
- Reset: hold `rst_n` low mid-SHIFT → immediately `sensor_cs_n`=1, `sensor_sclk`=0, `temperature`=20, `temp_valid`=0, `sensor_err`=0.
- Raw read, macro off, `SCLK_DIV`=4: sensor returns 8'd19 → `sensor_cs_n` low for 64 cycles with 8 `sensor_sclk` rises, then `temp_valid` pulse at cycle 65 with `temperature`=19.
- Saturation: sensor returns 8'd45 → `temperature`=31 with `temp_valid`.
- Error frame: 8'hFF → `sensor_err`=1, no `temp_valid`, `temperature` holds. Next frame 8'd22 → `sensor_err`=0, `temp_valid`, `temperature`=22.
- `TEMP_AVG_EN` defined: readings 16, 18, 20, 23 → `temperature` = 16, 16, 17, 19 on successive strobes.
- `enable` dropped during SHIFT → `sensor_cs_n`=1 the next cycle and no strobe. Re-raising `enable` starts a new frame the following cycle, and it completes normally.
